// File: rtl/alu_sched_pkg.sv
// Shared ALU encodings and scheduler state type for the ALU scheduler slice.
package alu_sched_pkg;

  localparam int unsigned REG_WIDTH   = 8;
  localparam int unsigned OPP_WIDTH   = 8;
  localparam int unsigned CARRY       = 0;
  localparam int unsigned ALU_LAT_DEF = 1;

  // One-hot ALU function selects
  localparam logic [OPP_WIDTH-1:0] OP_SUM = 8'b0000_0001;
  localparam logic [OPP_WIDTH-1:0] OP_AND = 8'b0000_0010;
  localparam logic [OPP_WIDTH-1:0] OP_OR  = 8'b0000_0100;
  localparam logic [OPP_WIDTH-1:0] OP_XOR = 8'b0000_1000;
  localparam logic [OPP_WIDTH-1:0] OP_SR  = 8'b0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EX_RUN,
    ST_AG_LO,
    ST_AG_HI,
    ST_ACK
  } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter between EX and AG; remembers which side was last served.
module alu_rr_arb (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_ex,
  input  logic i_req_ag,
  input  logic i_upd,
  input  logic i_upd_ag,
  output logic o_gnt_valid,
  output logic o_gnt_ag
);

  logic r_last_ag;

  // Reset to AG so EX wins the first tie
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_ag <= 1'b1;
    end else if (i_upd) begin
      r_last_ag <= i_upd_ag;
    end
  end

  assign o_gnt_valid = i_req_ex | i_req_ag;
  assign o_gnt_ag    = i_req_ag & (~i_req_ex | ~r_last_ag);

endmodule

// File: rtl/alu_sched.sv
// Shares one 8-bit ALU between the execute unit and the address generator,
// sequencing AG adds as one or two byte passes.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned ALU_LAT = ALU_LAT_DEF,
  parameter int unsigned AW      = 2 * REG_WIDTH
) (
  input  logic                 phi1,
  input  logic                 reset_n,
  input  logic                 ex_req,
  input  logic [OPP_WIDTH-1:0] ex_func,
  input  logic [REG_WIDTH-1:0] ex_a,
  input  logic [REG_WIDTH-1:0] ex_b,
  input  logic [REG_WIDTH-1:0] ex_status_in,
  output logic                 ex_ack,
  output logic [REG_WIDTH-1:0] ex_dout,
  output logic [REG_WIDTH-1:0] ex_status,
  input  logic                 ag_req,
  input  logic [AW-1:0]        ag_base,
  input  logic [REG_WIDTH-1:0] ag_index,
  output logic                 ag_ack,
  output logic [AW-1:0]        ag_addr,
  output logic                 ag_page_cross,
  output logic                 busy,
  output logic [OPP_WIDTH-1:0] alu_func,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic [REG_WIDTH-1:0] alu_status_in,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic [REG_WIDTH-1:0] alu_status_out
);

  localparam logic [1:0] WAIT_LAST = 2'(ALU_LAT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_gnt_valid;
  logic                 w_gnt_ag;
  logic                 w_done;
  logic                 w_carry;
  logic                 w_upd;
  logic                 r_sel_ag;
  logic [1:0]           r_wait;
  logic [OPP_WIDTH-1:0] r_func;
  logic [REG_WIDTH-1:0] r_a;
  logic [REG_WIDTH-1:0] r_b;
  logic [REG_WIDTH-1:0] r_status;
  logic [AW-1:0]        r_base;
  logic [REG_WIDTH-1:0] r_index;
  logic [REG_WIDTH-1:0] r_lo;
  logic [REG_WIDTH-1:0] r_ex_dout;
  logic [REG_WIDTH-1:0] r_ex_status;
  logic [AW-1:0]        r_ag_addr;
  logic                 r_page_cross;

  assign w_upd   = (r_state == ST_ACK);
  assign w_done  = (r_wait == WAIT_LAST);
  assign w_carry = alu_status_out[CARRY];

  alu_rr_arb u_arb (
    .i_clk       (phi1),
    .i_rst_n     (reset_n),
    .i_req_ex    (ex_req),
    .i_req_ag    (ag_req),
    .i_upd       (w_upd),
    .i_upd_ag    (r_sel_ag),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_ag    (w_gnt_ag)
  );

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    alu_func      = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_status_in = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) w_state_nxt = w_gnt_ag ? ST_AG_LO : ST_EX_RUN;
      end
      ST_EX_RUN: begin
        alu_func      = r_func;
        alu_a         = r_a;
        alu_b         = r_b;
        alu_status_in = r_status;
        if (w_done) w_state_nxt = ST_ACK;
      end
      ST_AG_LO: begin
        alu_func = OP_SUM;
        alu_a    = r_base[REG_WIDTH-1:0];
        alu_b    = r_index;
        if (w_done) w_state_nxt = w_carry ? ST_AG_HI : ST_ACK;
      end
      // High byte only needs +1, so it is fed as hi + 0 with carry-in set
      ST_AG_HI: begin
        alu_func             = OP_SUM;
        alu_a                = r_base[AW-1:REG_WIDTH];
        alu_status_in[CARRY] = 1'b1;
        if (w_done) w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_ag     <= 1'b0;
      r_wait       <= '0;
      r_func       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_status     <= '0;
      r_base       <= '0;
      r_index      <= '0;
      r_lo         <= '0;
      r_ex_dout    <= '0;
      r_ex_status  <= '0;
      r_ag_addr    <= '0;
      r_page_cross <= 1'b0;
    end else begin
      if ((r_state inside {ST_EX_RUN, ST_AG_LO, ST_AG_HI}) && !w_done) begin
        r_wait <= r_wait + 2'd1;
      end else begin
        r_wait <= '0;
      end

      if (r_state == ST_IDLE && w_gnt_valid) begin
        r_sel_ag <= w_gnt_ag;
        if (w_gnt_ag) begin
          r_base  <= ag_base;
          r_index <= ag_index;
        end else begin
          r_func   <= ex_func;
          r_a      <= ex_a;
          r_b      <= ex_b;
          r_status <= ex_status_in;
        end
      end

      if (w_done) begin
        case (r_state)
          ST_EX_RUN: begin
            r_ex_dout   <= alu_dout;
            r_ex_status <= alu_status_out;
          end
          ST_AG_LO: begin
            r_lo <= alu_dout;
            if (!w_carry) begin
              r_ag_addr    <= {r_base[AW-1:REG_WIDTH], alu_dout};
              r_page_cross <= 1'b0;
            end
          end
          ST_AG_HI: begin
            r_ag_addr    <= {alu_dout, r_lo};
            r_page_cross <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ex_ack        = w_upd & ~r_sel_ag;
  assign ag_ack        = w_upd & r_sel_ag;
  assign busy          = (r_state != ST_IDLE);
  assign ex_dout       = r_ex_dout;
  assign ex_status     = r_ex_status;
  assign ag_addr       = r_ag_addr;
  assign ag_page_cross = r_page_cross;

endmodule
